// File: rtl/getir_tamponu_pkg.sv
// Shared fetch-stage types and constants for the fetch buffer.
// Entry layout: instruction word plus its program counter.
package getir_tamponu_pkg;

    localparam logic [31:0] NOP_BUYRUK = 32'h0000_0013;
    localparam int VARS_DERINLIK = 8;
    localparam int VARS_OBEK_BUYRUK = 4;

    typedef struct packed {
        logic [31:0] buyruk;
        logic [31:0] ps;
    } girdi_t;

endpackage

// File: rtl/getir_tamponu_bellek.sv
// Fetch buffer storage: multi-lane write, one async read port.
// Lane k writes entry (yaz_ptr + k) mod DERINLIK; contents are not reset.
module getir_tamponu_bellek
    import getir_tamponu_pkg::*;
#(
    parameter int DERINLIK    = VARS_DERINLIK,
    parameter int OBEK_BUYRUK = VARS_OBEK_BUYRUK,
    localparam int AW         = $clog2(DERINLIK)
) (
    input  logic                   clk_i,
    input  logic [OBEK_BUYRUK-1:0] yaz_en,
    input  logic [AW-1:0]          yaz_ptr,
    input  girdi_t                 yaz_veri [OBEK_BUYRUK],
    input  logic [AW-1:0]          oku_ptr,
    output girdi_t                 oku_veri
);

    girdi_t dizi [DERINLIK];

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < OBEK_BUYRUK; k++) begin
            if (yaz_en[k]) begin
                dizi[yaz_ptr + AW'(k)] <= yaz_veri[k];
            end
        end
    end

    assign oku_veri = dizi[oku_ptr];

endmodule

// File: rtl/getir_tamponu.sv
// Fetch buffer: block writes in, one instruction per cycle out, 1-cycle flush.
// Optional same-cycle bypass into an empty buffer: GETIR_TAMPONU_BYPASS_EN.
module getir_tamponu
    import getir_tamponu_pkg::*;
#(
    parameter int DERINLIK    = VARS_DERINLIK,
    parameter int OBEK_BUYRUK = VARS_OBEK_BUYRUK,
    localparam int AW         = $clog2(DERINLIK),
    localparam int CW         = AW + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      obek_gecerli_i,
    input  logic [32*OBEK_BUYRUK-1:0] obek_i,
    input  logic [31:0]               obek_ps_i,
    output logic                      obek_hazir_o,
    input  logic                      temizle_i,
    output logic                      buyruk_gecerli_o,
    output logic [31:0]               buyruk_o,
    output logic [31:0]               buyruk_ps_o,
    input  logic                      buyruk_hazir_i,
    output logic [CW-1:0]             doluluk_o
);

    localparam int OW = $clog2(OBEK_BUYRUK);
    localparam logic [CW:0] DER_L = DERINLIK[CW:0];
    localparam logic [CW:0] OBEK_L = OBEK_BUYRUK[CW:0];

    logic [AW-1:0] yaz_ptr;
    logic [AW-1:0] oku_ptr;
    logic [CW-1:0] doluluk;
    logic [OW-1:0] ofs;
    logic          bos;
    logic          yaz;
    logic          atla;
    logic          atla_oku;
    logic          depo_oku;
    logic [CW-1:0] n_yaz;
    logic [OBEK_BUYRUK-1:0] yaz_en;
    girdi_t        yaz_veri [OBEK_BUYRUK];
    girdi_t        oku_veri;

    assign ofs = obek_ps_i[OW+1:2];
    assign bos = (doluluk == '0);

    // Space for a full block is reserved whatever the offset.
    assign obek_hazir_o = !temizle_i
        && ((DER_L - {1'b0, doluluk}) >= OBEK_L);
    assign yaz = obek_gecerli_i && obek_hazir_o;

`ifdef GETIR_TAMPONU_BYPASS_EN
    assign atla = bos && yaz;
`else
    assign atla = 1'b0;
`endif

    assign buyruk_gecerli_o = !temizle_i && (!bos || atla);
    assign atla_oku = atla && buyruk_hazir_i;
    assign depo_oku = buyruk_gecerli_o && buyruk_hazir_i && !bos;

    always_comb begin
        n_yaz = '0;
        if (yaz) begin
            n_yaz = CW'(OBEK_BUYRUK - int'(ofs) - int'(atla_oku));
        end
    end

    // Lane k carries block word ofs+k (+1 when the bypass consumed word ofs).
    always_comb begin
        for (int k = 0; k < OBEK_BUYRUK; k++) begin
            int src;
            src = k + int'(ofs) + int'(atla_oku);
            yaz_en[k] = 1'b0;
            yaz_veri[k].buyruk = '0;
            yaz_veri[k].ps = obek_ps_i + 32'(4 * (k + int'(atla_oku)));
            if (src < OBEK_BUYRUK) begin
                yaz_en[k] = yaz;
                yaz_veri[k].buyruk = obek_i[32*src +: 32];
            end
        end
    end

    getir_tamponu_bellek #(
        .DERINLIK    (DERINLIK),
        .OBEK_BUYRUK (OBEK_BUYRUK)
    ) u_bellek (
        .clk_i    (clk_i),
        .yaz_en   (yaz_en),
        .yaz_ptr  (yaz_ptr),
        .yaz_veri (yaz_veri),
        .oku_ptr  (oku_ptr),
        .oku_veri (oku_veri)
    );

    always_comb begin
        buyruk_o = NOP_BUYRUK;
        buyruk_ps_o = '0;
        if (atla) begin
            buyruk_o = obek_i[32*int'(ofs) +: 32];
            buyruk_ps_o = obek_ps_i;
        end else if (buyruk_gecerli_o) begin
            buyruk_o = oku_veri.buyruk;
            buyruk_ps_o = oku_veri.ps;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            yaz_ptr <= '0;
            oku_ptr <= '0;
            doluluk <= '0;
        end else if (temizle_i) begin
            yaz_ptr <= '0;
            oku_ptr <= '0;
            doluluk <= '0;
        end else begin
            yaz_ptr <= yaz_ptr + AW'(n_yaz);
            oku_ptr <= oku_ptr + AW'(depo_oku);
            doluluk <= doluluk + n_yaz - CW'(depo_oku);
        end
    end

    assign doluluk_o = doluluk;

endmodule
